imm_pack: RTL and testbench
===========================

// Module: imm_pack
// PURPOSE
//  Inverse of the immediate extender: packs a 32-bit operand back into the field of a 32-bit MIPS
//  instruction selected by ExtOp (0 zext imm16, 1 sext imm16, 2 shamt, 3 target).
//  Checks the operand survives the extend round trip and flags it if it does not.
//  Streams packed words into a 2-entry output FIFO and assigns each one a word address,
//  ready to be written into instruction memory (loader / self-test path).
// PARAMETERS
//  ADDR_W     10  width of output word-address counter
//  BASE_ADDR  0   out_addr value of first word after reset
//  ERR_CNT_W  8   width of saturating range-error counter
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       input word offered
//  in_ready   out  1       input accepted when in_valid & in_ready
//  in_base    in   32      instruction skeleton; bits outside the target field are kept
//  in_imm     in   32      operand value to pack
//  in_extop   in   2       field select, same encoding as ExtOp
//  out_valid  out  1       FIFO head valid
//  out_ready  in   1       head consumed when out_valid & out_ready
//  out_instr  out  32      packed instruction at FIFO head
//  out_addr   out  ADDR_W  word address of FIFO head
//  out_err    out  1       head operand failed range check
//  err_cnt    out  ERR_CNT_W  total range errors since reset, saturates at all-ones
// BEHAVIOUR
//  - Reset: FIFO empty, out_valid=0, out_instr=0, out_err=0, addr counter=BASE_ADDR, err_cnt=0.
//  - in_ready = (fifo count < 2); never depends on out_ready combinationally.
//  - Field insert: extop 0/1 -> instr[15:0]=imm[15:0]; extop 2 -> instr[10:6]=imm[4:0];
//    extop 3 -> instr[25:0]=imm[25:0]; all other bits from in_base.
//  - Range error: extop0 imm[31:16]!=0; extop1 imm[31:15] not all equal; extop2 imm[31:5]!=0;
//    extop3 imm[31:26]!=0. A word with an error is still packed (truncated field).
//  - Latency: accepted word is at FIFO head (out_valid=1) the next cycle if FIFO was empty.
//  - Address: assigned at enqueue from an enqueue counter, +1 per enqueued word, wraps
//    2^ADDR_W-1 -> 0. out_addr/out_instr/out_err are stable while out_valid & ~out_ready.
//  - FIFO: order preserved; simultaneous push and pop at count 1 leaves count 1 and the
//    new word becomes head next cycle; pop at count 2 with push blocked (in_ready=0).
//  - err_cnt increments once per accepted erroneous word; holds at 2^ERR_CNT_W-1.
//  - Pop when empty or push when full cannot occur (gated by valid/ready); no other state.
//  - Reset mid-stream: discards FIFO contents, restarts address at BASE_ADDR.
// CONFIGURATION
//  IMM_PACK_DROP_ERR_EN defined: erroneous words are not enqueued and do not advance the
//    address counter; err_cnt still increments; out_err is constant 0.
//  Not defined: erroneous words pass through with out_err=1 and consume an address.
// TESTING
//  1 reset; base=0x20080000, imm=0x00001234, extop0, out_ready=1 -> next cycle out_valid=1,
//    out_instr=0x20081234, out_addr=0, out_err=0.
//  2 extop1 imm=0xFFFF8000 -> field 0x8000, err=0; imm=0x00008000 -> err=1, err_cnt=1
//    (with IMM_PACK_DROP_ERR_EN: no output, addr unchanged, err_cnt=1).
//  3 extop2 base=0x00000000 imm=31 -> out_instr=0x000007C0; imm=32 -> err=1, field=0.
//  4 extop3 base=0x0C000000 imm=0x03FFFFFF -> 0x0FFFFFFF, err=0; imm=0x04000000 -> err=1.
//  5 out_ready=0, push 3 words -> in_ready=0 after 2, third held; head stable; release
//    out_ready -> words out in order, addrs 0,1,2; ADDR_W=2 run of 5 words -> addrs 0,1,2,3,0.
//  6 assert reset with 2 words queued -> next cycle out_valid=0, next word gets BASE_ADDR.

Source files
------------

// File: rtl/imm_pack.sv
// imm_pack -- inverse of the MIPS immediate extender.
//
// Packs a 32-bit operand into the instruction field selected by in_extop
// (0 zext imm16, 1 sext imm16, 2 shamt, 3 jump target). It also checks that
// the operand would survive the extend round trip, and queues the packed
// word in a 2-entry FIFO. Each queued word gets a sequential word address,
// so the stream can be written straight into instruction memory.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  input handshake; in_ready = FIFO not full
//   in_base              instruction skeleton (bits outside the field are kept)
//   in_imm               operand to pack
//   in_extop             field select
//   out_valid/out_ready  FIFO head handshake
//   out_instr            packed instruction at the FIFO head
//   out_addr             word address of the FIFO head
//   out_err              head operand failed the range check
//   err_cnt              saturating count of range errors since reset
//
// Build option IMM_PACK_DROP_ERR_EN: words that fail the range check are
// dropped instead of queued. They still bump err_cnt, they do not consume an
// address, and out_err is tied low.
module imm_pack #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_base,
  input  logic [31:0]          in_imm,
  input  logic [1:0]           in_extop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ADDR_W-1:0]    BASE_ADDR_C = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]    ADDR_ONE_C  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE_C   = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] ERR_MAX_C   = {ERR_CNT_W{1'b1}};

  // Overwrite only the field selected by op; all other bits come from base.
  function automatic logic [31:0] pack_field(input logic [31:0] base,
                                             input logic [31:0] imm,
                                             input logic [1:0]  op);
    logic [31:0] res_s;
    res_s = base;
    case (op)
      2'd0, 2'd1: res_s[15:0] = imm[15:0];
      2'd2:       res_s[10:6] = imm[4:0];
      2'd3:       res_s[25:0] = imm[25:0];
      default:    res_s       = base;
    endcase
    return res_s;
  endfunction

  // The operand is out of range if re-extending the packed field would not
  // give back the original value.
  function automatic logic range_err(input logic [31:0] imm,
                                     input logic [1:0]  op);
    logic bad_s;
    case (op)
      2'd0:    bad_s = |imm[31:16];
      // sext: bits 31..15 must all be copies of the sign bit
      2'd1:    bad_s = ~((&imm[31:15]) | (~|imm[31:15]));
      2'd2:    bad_s = |imm[31:5];
      2'd3:    bad_s = |imm[31:26];
      default: bad_s = 1'b0;
    endcase
    return bad_s;
  endfunction

  logic [1:0]           count_r,      count_nx_s;
  logic [31:0]          head_instr_r, head_instr_nx_s;
  logic [ADDR_W-1:0]    head_addr_r,  head_addr_nx_s;
  logic                 head_err_r,   head_err_nx_s;
  logic [31:0]          tail_instr_r, tail_instr_nx_s;
  logic [ADDR_W-1:0]    tail_addr_r,  tail_addr_nx_s;
  logic                 tail_err_r,   tail_err_nx_s;
  logic [ADDR_W-1:0]    enq_addr_r,   enq_addr_nx_s;
  logic [ERR_CNT_W-1:0] err_cnt_r,    err_cnt_nx_s;

  logic        accept_s;
  logic        bad_s;
  logic        enq_s;
  logic        pop_s;
  logic        new_err_s;
  logic [31:0] new_instr_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign out_instr = head_instr_r;
  assign out_addr  = head_addr_r;
  assign out_err   = head_err_r;
  assign err_cnt   = err_cnt_r;

  // Handshake decode and packing of the incoming word.
  always_comb begin
    accept_s    = in_valid & in_ready;
    bad_s       = range_err(in_imm, in_extop);
    new_instr_s = pack_field(in_base, in_imm, in_extop);
    pop_s       = out_valid & out_ready;
`ifdef IMM_PACK_DROP_ERR_EN
    enq_s       = accept_s & ~bad_s;
    new_err_s   = 1'b0;
`else
    enq_s       = accept_s;
    new_err_s   = bad_s;
`endif
  end

  // FIFO, address counter and error counter next-state.
  always_comb begin
    count_nx_s      = count_r;
    head_instr_nx_s = head_instr_r;
    head_addr_nx_s  = head_addr_r;
    head_err_nx_s   = head_err_r;
    tail_instr_nx_s = tail_instr_r;
    tail_addr_nx_s  = tail_addr_r;
    tail_err_nx_s   = tail_err_r;
    enq_addr_nx_s   = enq_addr_r;
    err_cnt_nx_s    = err_cnt_r;

    case (count_r)
      2'd0: begin
        if (enq_s) begin
          head_instr_nx_s = new_instr_s;
          head_addr_nx_s  = enq_addr_r;
          head_err_nx_s   = new_err_s;
          count_nx_s      = 2'd1;
        end else begin
          count_nx_s      = 2'd0;
        end
      end
      2'd1: begin
        if (enq_s) begin
          if (pop_s) begin
            // push and pop together: the new word replaces the head
            head_instr_nx_s = new_instr_s;
            head_addr_nx_s  = enq_addr_r;
            head_err_nx_s   = new_err_s;
            count_nx_s      = 2'd1;
          end else begin
            tail_instr_nx_s = new_instr_s;
            tail_addr_nx_s  = enq_addr_r;
            tail_err_nx_s   = new_err_s;
            count_nx_s      = 2'd2;
          end
        end else if (pop_s) begin
          count_nx_s = 2'd0;
        end else begin
          count_nx_s = 2'd1;
        end
      end
      2'd2: begin
        // push is blocked at count 2 because in_ready is low
        if (pop_s) begin
          head_instr_nx_s = tail_instr_r;
          head_addr_nx_s  = tail_addr_r;
          head_err_nx_s   = tail_err_r;
          count_nx_s      = 2'd1;
        end else begin
          count_nx_s      = 2'd2;
        end
      end
      default: count_nx_s = 2'd0;
    endcase

    if (enq_s) begin
      enq_addr_nx_s = enq_addr_r + ADDR_ONE_C;
    end else begin
      enq_addr_nx_s = enq_addr_r;
    end

    if (accept_s && bad_s && (err_cnt_r != ERR_MAX_C)) begin
      err_cnt_nx_s = err_cnt_r + ERR_ONE_C;
    end else begin
      err_cnt_nx_s = err_cnt_r;
    end
  end

  // State registers; reset empties the FIFO and restarts the address.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r      <= 2'd0;
      head_instr_r <= 32'h0000_0000;
      head_addr_r  <= '0;
      head_err_r   <= 1'b0;
      tail_instr_r <= 32'h0000_0000;
      tail_addr_r  <= '0;
      tail_err_r   <= 1'b0;
      enq_addr_r   <= BASE_ADDR_C;
      err_cnt_r    <= '0;
    end else begin
      count_r      <= count_nx_s;
      head_instr_r <= head_instr_nx_s;
      head_addr_r  <= head_addr_nx_s;
      head_err_r   <= head_err_nx_s;
      tail_instr_r <= tail_instr_nx_s;
      tail_addr_r  <= tail_addr_nx_s;
      tail_err_r   <= tail_err_nx_s;
      enq_addr_r   <= enq_addr_nx_s;
      err_cnt_r    <= err_cnt_nx_s;
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// Self-checking bench for imm_pack. It uses two instances with shared
// inputs: the default one and a narrow one (ADDR_W=2, ERR_CNT_W=2), so that
// address wrap and counter saturation are reachable. Expected values come
// from directed constants and from a queue-based reference model.
module tb_imm_pack;

`ifdef IMM_PACK_DROP_ERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic [1:0]  in_extop;
  logic        out_ready;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic [7:0]  err_cnt;

  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] out_instr2;
  logic [1:0]  out_addr2;
  logic [1:0]  err_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] instr;
    int          addr;
    logic        err;
  } entry_t;

  entry_t m_q[$];
  int     m_addr;
  int     m_errs;
  int     m_errs2;

  imm_pack dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_imm(in_imm), .in_extop(in_extop),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  imm_pack #(.ADDR_W(2), .BASE_ADDR(0), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_base(in_base), .in_imm(in_imm), .in_extop(in_extop),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_addr(out_addr2), .out_err(out_err2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: field insert with masks and arithmetic.
  function automatic logic [31:0] ref_pack(input logic [31:0] b, input logic [31:0] imm,
                                           input logic [1:0] op);
    case (op)
      2'd0, 2'd1: return (b & 32'hFFFF_0000) | (imm & 32'h0000_FFFF);
      2'd2:       return (b & ~32'h0000_07C0) | ((imm % 32) * 64);
      default:    return (b & 32'hFC00_0000) | (imm & 32'h03FF_FFFF);
    endcase
  endfunction

  // Reference: the value is out of range of the field's numeric range.
  function automatic bit ref_err(input logic [31:0] imm, input logic [1:0] op);
    longint s;
    s = longint'($signed(imm));
    case (op)
      2'd0:    return imm > 32'd65535;
      2'd1:    return (s < -64'sd32768) || (s > 64'sd32767);
      2'd2:    return imm > 32'd31;
      default: return imm > 32'h03FF_FFFF;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_base = 32'd0; in_imm = 32'd0;
    in_extop = 2'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_q.delete(); m_addr = 0; m_errs = 0; m_errs2 = 0;
  endtask

  // Drive one cycle and advance the reference model; sample at posedge+1.
  task automatic step(input logic v, input logic [31:0] b, input logic [31:0] imm,
                      input logic [1:0] op, input logic ordy);
    bit acc, pop, e;
    entry_t ent;
    in_valid = v; in_base = b; in_imm = imm; in_extop = op; out_ready = ordy;
    acc = v && (m_q.size() < 2);
    pop = (m_q.size() > 0) && ordy;
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      e = ref_err(imm, op);
      if (e) begin
        if (m_errs < 255) m_errs++;
        if (m_errs2 < 3) m_errs2++;
      end
      if (!(DROP && e)) begin
        ent.instr = ref_pack(b, imm, op);
        ent.addr  = m_addr;
        ent.err   = DROP ? 1'b0 : e;
        m_q.push_back(ent);
        m_addr = (m_addr + 1) % 1024;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    n_checks++; if (out_instr !== 32'd0) begin n_errors++; $display("FAIL reset_instr got %h exp 0", out_instr); end
    n_checks++; if (out_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %0b exp 0", out_err); end
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_errcnt got %0d exp 0", err_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_inready got %0b exp 1", in_ready); end
  endtask

  task automatic test_zext();
    do_reset();
    step(1'b1, 32'h2008_0000, 32'h0000_1234, 2'd0, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL zext_valid got %0b exp 1", out_valid); end
    n_checks++; if (out_instr !== 32'h2008_1234) begin n_errors++; $display("FAIL zext_instr got %h exp 20081234", out_instr); end
    n_checks++; if (out_addr !== 10'd0) begin n_errors++; $display("FAIL zext_addr got %0d exp 0", out_addr); end
    n_checks++; if (out_err !== 1'b0) begin n_errors++; $display("FAIL zext_err got %0b exp 0", out_err); end
    step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL zext_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_sext();
    do_reset();
    step(1'b1, 32'd0, 32'hFFFF_8000, 2'd1, 1'b1);
    n_checks++; if (out_instr !== 32'h0000_8000 || out_err !== 1'b0)
      begin n_errors++; $display("FAIL sext_neg got %h/%0b exp 00008000/0", out_instr, out_err); end
    step(1'b1, 32'd0, 32'h0000_8000, 2'd1, 1'b1);
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL sext_errcnt got %0d exp 1", err_cnt); end
    if (DROP) begin
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL sext_drop got %0b exp 0", out_valid); end
    end else begin
      n_checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_8000 || out_err !== 1'b1 || out_addr !== 10'd1)
        begin n_errors++; $display("FAIL sext_bad got v%0b %h e%0b a%0d exp v1 00008000 e1 a1", out_valid, out_instr, out_err, out_addr); end
    end
    step(1'b1, 32'd0, 32'h0000_7FFF, 2'd1, 1'b1);
    n_checks++; if (out_addr !== (DROP ? 10'd1 : 10'd2) || out_instr !== 32'h0000_7FFF || out_err !== 1'b0)
      begin n_errors++; $display("FAIL sext_next got a%0d %h e%0b exp a%0d 00007fff e0", out_addr, out_instr, out_err, DROP ? 1 : 2); end
    step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
  endtask

  task automatic test_shamt();
    do_reset();
    step(1'b1, 32'd0, 32'd31, 2'd2, 1'b1);
    n_checks++; if (out_instr !== 32'h0000_07C0 || out_err !== 1'b0)
      begin n_errors++; $display("FAIL shamt_ok got %h/%0b exp 000007c0/0", out_instr, out_err); end
    step(1'b1, 32'd0, 32'd32, 2'd2, 1'b1);
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL shamt_errcnt got %0d exp 1", err_cnt); end
    if (!DROP) begin
      n_checks++; if (out_valid !== 1'b1 || out_instr !== 32'd0 || out_err !== 1'b1)
        begin n_errors++; $display("FAIL shamt_bad got v%0b %h e%0b exp v1 0 e1", out_valid, out_instr, out_err); end
    end
    step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
  endtask

  task automatic test_target();
    do_reset();
    step(1'b1, 32'h0C00_0000, 32'h03FF_FFFF, 2'd3, 1'b1);
    n_checks++; if (out_instr !== 32'h0FFF_FFFF || out_err !== 1'b0)
      begin n_errors++; $display("FAIL target_ok got %h/%0b exp 0fffffff/0", out_instr, out_err); end
    step(1'b1, 32'h0C00_0000, 32'h0400_0000, 2'd3, 1'b1);
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL target_errcnt got %0d exp 1", err_cnt); end
    if (!DROP) begin
      n_checks++; if (out_instr !== 32'h0C00_0000 || out_err !== 1'b1)
        begin n_errors++; $display("FAIL target_bad got %h/%0b exp 0c000000/1", out_instr, out_err); end
    end
    step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 32'd0, 32'd1, 2'd0, 1'b0);
    n_checks++; if (in_ready !== 1'b1 || out_addr !== 10'd0)
      begin n_errors++; $display("FAIL bp_one got r%0b a%0d exp r1 a0", in_ready, out_addr); end
    step(1'b1, 32'd0, 32'd2, 2'd0, 1'b0);
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full got %0b exp 0", in_ready); end
    step(1'b1, 32'd0, 32'd3, 2'd0, 1'b0);
    n_checks++; if (in_ready !== 1'b0 || out_instr !== 32'd1 || out_addr !== 10'd0)
      begin n_errors++; $display("FAIL bp_hold got r%0b %h a%0d exp r0 1 a0", in_ready, out_instr, out_addr); end
    step(1'b1, 32'd0, 32'd3, 2'd0, 1'b1);
    n_checks++; if (in_ready !== 1'b1 || out_instr !== 32'd2 || out_addr !== 10'd1)
      begin n_errors++; $display("FAIL bp_pop1 got r%0b %h a%0d exp r1 2 a1", in_ready, out_instr, out_addr); end
    step(1'b1, 32'd0, 32'd3, 2'd0, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_instr !== 32'd3 || out_addr !== 10'd2)
      begin n_errors++; $display("FAIL bp_pushpop got v%0b %h a%0d exp v1 3 a2", out_valid, out_instr, out_addr); end
    step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_addr_wrap();
    int exp_a[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'd0, 32'(i), 2'd0, 1'b1);
      n_checks++; if (out_valid2 !== 1'b1 || out_addr2 !== 2'(exp_a[i]))
        begin n_errors++; $display("FAIL wrap_addr[%0d] got %0d exp %0d", i, out_addr2, exp_a[i]); end
    end
    step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(1'b1, 32'd0, 32'd5, 2'd0, 1'b0);
    step(1'b1, 32'd0, 32'd6, 2'd0, 1'b0);
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL mrst_full got %0b exp 0", in_ready); end
    do_reset();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_errors++; $display("FAIL mrst_flush got v%0b r%0b exp v0 r1", out_valid, in_ready); end
    step(1'b1, 32'd0, 32'd7, 2'd0, 1'b1);
    n_checks++; if (out_addr !== 10'd0 || out_instr !== 32'd7)
      begin n_errors++; $display("FAIL mrst_addr got a%0d %h exp a0 7", out_addr, out_instr); end
    step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] imm;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       imm = 32'($urandom_range(0, 40));
        1:       imm = $urandom & 32'h0001_FFFF;
        2:       imm = 32'hFFFF_0000 | ($urandom & 32'h0000_FFFF);
        default: imm = $urandom;
      endcase
      step(1'($urandom_range(0, 3) != 0), $urandom, imm, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) != 0));
      n_checks++; if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2))
        begin n_errors++; $display("FAIL rnd_flags[%0d] got v%0b r%0b exp q%0d", i, out_valid, in_ready, m_q.size()); end
      n_checks++; if (err_cnt !== 8'(m_errs) || err_cnt2 !== 2'(m_errs2))
        begin n_errors++; $display("FAIL rnd_errcnt[%0d] got %0d/%0d exp %0d/%0d", i, err_cnt, err_cnt2, m_errs, m_errs2); end
      if (m_q.size() > 0) begin
        n_checks++;
        if (out_instr !== m_q[0].instr || out_addr !== 10'(m_q[0].addr) || out_err !== m_q[0].err ||
            out_addr2 !== 2'(m_q[0].addr % 4) || out_instr2 !== m_q[0].instr)
          begin n_errors++; $display("FAIL rnd_head[%0d] got %h a%0d e%0b exp %h a%0d e%0b", i,
                                     out_instr, out_addr, out_err, m_q[0].instr, m_q[0].addr, m_q[0].err); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zext();
    test_sext();
    test_shamt();
    test_target();
    test_back_to_back();
    test_addr_wrap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
